// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: stalls the pipe while it
// steps one multiplier bit per cycle, then pulses done_o with the low product.
module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic [WIDTH-1:0] mplier_sh;

  assign mplier_sh = mplier >> 1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    stall_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept   = 1'b1;
          stall_o  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (flush_i)                            state_nx = IDLE;
        else if (cnt == LAST)                   state_nx = DONE;
        else if (EARLY_EXIT && mplier_sh == '0) state_nx = DONE;
      end
      // start_i still belongs to the finishing instruction here; never restart.
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A flushed step is dropped so acc keeps the partial sum it had.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= src1_i;
      mplier <= src2_i;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN && !flush_i) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier_sh;
      cnt    <= cnt + 1'b1;
    end
  end

  assign done_o   = (state == DONE);
  assign result_o = acc;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: one full-length instance and one early-exit
// instance, checked against hand-computed products and cycle counts.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, flush;
  logic [31:0] src1, src2;
  logic        stall_a, done_a, stall_b, done_b;
  logic [31:0] result_a, result_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_full (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .flush_i(flush),
    .src1_i(src1), .src2_i(src2),
    .stall_o(stall_a), .done_o(done_a), .result_o(result_a)
  );

  mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_early (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .flush_i(flush),
    .src1_i(src1), .src2_i(src2),
    .stall_o(stall_b), .done_o(done_b), .result_o(result_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Raise start with the given operands (called just after a posedge or at the
  // negedge of a DONE cycle). Cycle 0 is the accepting cycle. Returns at the
  // negedge of the done cycle with start still high.
  task automatic run_mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         output int nstall, output int done_cyc,
                         output logic [31:0] res, output bit stall_at_done, output bit ok);
    src1 = a;
    src2 = b;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    nstall = 0; done_cyc = -1; res = '0; stall_at_done = 1'b0; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        done_cyc      = c;
        res           = sel ? result_b : result_a;
        stall_at_done = sel ? stall_b : stall_a;
        ok            = 1'b1;
        break;
      end
      if (sel ? stall_b : stall_a) nstall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  int          ns, dc;
  logic [31:0] r;
  bit          sd, ok;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; flush = 1'b0;
    src1 = '0; src2 = '0;
    #12;
    chk("rst_stall", {31'b0, stall_a}, 32'd0);
    chk("rst_done",  {31'b0, done_a},  32'd0);
    chk("rst_result", result_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    step();

    // 7 x 6, full length
    run_mul(1'b0, 32'd7, 32'd6, ns, dc, r, sd, ok);
    chk("m1_seen", {31'b0, ok}, 32'd1);
    chk("m1_stall_cnt", ns, 32'd33);
    chk("m1_done_cyc", dc, 32'd33);
    chk("m1_result", r, 32'd42);
    chk("m1_stall_done", {31'b0, sd}, 32'd0);
    step(); start_a = 1'b0; #1;
    chk("m1_after_done", {31'b0, done_a}, 32'd0);
    chk("m1_after_stall", {31'b0, stall_a}, 32'd0);
    chk("m1_hold", result_a, 32'd42);

    // signed and overflow truncation
    run_mul(1'b0, 32'hFFFF_FFFD, 32'd5, ns, dc, r, sd, ok);
    chk("neg_result", r, 32'hFFFF_FFF1);
    step(); start_a = 1'b0; step();
    run_mul(1'b0, 32'h8000_0000, 32'd2, ns, dc, r, sd, ok);
    chk("ovf_result", r, 32'h0000_0000);
    step(); start_a = 1'b0; step();

    // early exit
    run_mul(1'b1, 32'h10, 32'd3, ns, dc, r, sd, ok);
    chk("ee3_done_cyc", dc, 32'd3);
    chk("ee3_stall_cnt", ns, 32'd3);
    chk("ee3_result", r, 32'h30);
    step(); start_b = 1'b0; step();
    run_mul(1'b1, 32'h10, 32'd0, ns, dc, r, sd, ok);
    chk("ee0_done_cyc", dc, 32'd2);
    chk("ee0_result", r, 32'd0);
    step(); start_b = 1'b0; step();

    // back-to-back with start held through DONE
    run_mul(1'b0, 32'd5, 32'd5, ns, dc, r, sd, ok);
    chk("b2b1_done_cyc", dc, 32'd33);
    chk("b2b1_result", r, 32'd25);
    run_mul(1'b0, 32'd9, 32'd9, ns, dc, r, sd, ok);
    chk("b2b2_done_cyc", dc, 32'd33);
    chk("b2b2_result", r, 32'd81);
    step(); start_a = 1'b0; step();

    // flush in RUN cycle 10
    src1 = 32'd7; src2 = 32'd6; start_a = 1'b1;
    repeat (10) step();
    chk("fl_run_stall", {31'b0, stall_a}, 32'd1);
    flush = 1'b1; start_a = 1'b0;
    step(); flush = 1'b0; #1;
    chk("fl_stall", {31'b0, stall_a}, 32'd0);
    begin
      int dcount = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done_a) dcount++;
      end
      chk("fl_no_done", dcount, 32'd0);
    end
    step();
    run_mul(1'b0, 32'd2, 32'd3, ns, dc, r, sd, ok);
    chk("fl_next_result", r, 32'd6);
    chk("fl_next_done_cyc", dc, 32'd33);
    step(); start_a = 1'b0; step();

    // asynchronous reset mid-RUN
    src1 = 32'd7; src2 = 32'd6; start_a = 1'b1;
    repeat (6) step();
    #2;
    chk("ar_pre_result", result_a, 32'd42);
    chk("ar_pre_stall", {31'b0, stall_a}, 32'd1);
    rst = 1'b1; start_a = 1'b0; #1;
    chk("ar_stall", {31'b0, stall_a}, 32'd0);
    chk("ar_done",  {31'b0, done_a},  32'd0);
    chk("ar_result", result_a, 32'd0);
    step(); step();
    @(negedge clk); rst = 1'b0;
    step();
    run_mul(1'b0, 32'd4, 32'd4, ns, dc, r, sd, ok);
    chk("ar_next_seen", {31'b0, ok}, 32'd1);
    chk("ar_next_result", r, 32'd16);
    step(); start_a = 1'b0; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle iterative multiplier controller for the EX stage.
- Invoked when ALU control decodes a mul (funct 011000, ALUCtrl 3'b010).
- Runs a one-bit-per-cycle shift-add sequence on the EX operands.
- Stalls the pipeline while busy, then presents the low WIDTH bits of the product for one cycle so EX/MEM can capture them.

Parameters:
- WIDTH, 32: operand and result width in bits.
- EARLY_EXIT, 0: when 1, finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  EX stage holds a mul instruction; level, stays high while that instruction sits in EX.
- flush_i  input  1  squash the EX instruction; aborts any operation in progress.
- src1_i  input  WIDTH  multiplicand (RS data after forwarding).
- src2_i  input  WIDTH  multiplier (RT data after forwarding).
- stall_o  output  1  hold PC, IF/ID and ID/EX this cycle.
- done_o  output  1  result_o valid this cycle; EX/MEM must capture.
- result_o  output  WIDTH  low WIDTH bits of src1 × src2.

Behaviour:
- States: IDLE, RUN, DONE.
- Internal registers:
  - mcand (WIDTH): multiplicand, shifted left each step.
  - mplier (WIDTH): multiplier, shifted right each step.
  - acc (WIDTH): accumulator; drives result_o.
  - cnt (clog2(WIDTH)+1 bits).
- Reset (async, rst_i=1): state=IDLE, mcand=mplier=acc=0, cnt=0. Outputs: stall_o=0, done_o=0, result_o=0. Applies immediately, including mid-RUN; the in-flight operation is discarded with no done_o.
- IDLE:
  - start_i=1 and flush_i=0: load mcand=src1_i, mplier=src2_i, acc=0, cnt=0; go to RUN.
  - Otherwise stay in IDLE; acc (result_o) is held.
- RUN, each cycle:
  - If mplier[0], acc <= acc + mcand, truncated to WIDTH bits.
  - mcand <= mcand << 1; mplier <= mplier >> 1 (logical); cnt <= cnt + 1.
  - Go to DONE if cnt==WIDTH-1.
  - If EARLY_EXIT=1, also go to DONE when (mplier>>1)==0 after this step.
  - Otherwise stay in RUN.
- DONE: one cycle only, then unconditionally to IDLE. start_i is ignored in DONE; it still refers to the same instruction, which leaves EX at the end of this cycle.
- flush_i=1 in RUN: go to IDLE next cycle, no done_o, acc keeps its partial value. flush_i in IDLE blocks a start; in DONE it has no effect.
- stall_o (combinational) = (IDLE and start_i and !flush_i) or RUN.
- done_o (registered-state decode) = (state==DONE).
- result_o = acc. Valid when done_o=1; held until the next accepted start.
- Latency with start accepted in cycle T:
  - EARLY_EXIT=0: RUN for cycles T+1..T+WIDTH, DONE at T+WIDTH+1. stall_o is high for WIDTH+1 cycles.
  - EARLY_EXIT=1: the number of RUN cycles is max(1, index of the highest set bit of src2 + 1). src2=0 gives 1 RUN cycle.
- Signedness: the low WIDTH bits of the product are identical for two's-complement and unsigned operands, so no sign handling is needed.
- Back-to-back muls: DONE→IDLE, then the next mul enters EX and is accepted in IDLE one cycle after DONE. Exactly one non-stalled cycle per mul, in DONE.
- Operands are sampled only on the IDLE→RUN transition; src changes during RUN have no effect.

Test Plan:
- EARLY_EXIT=0, src1=7, src2=6, start held high → stall_o high 33 cycles; done_o high exactly in cycle 34 with result_o=42; stall_o=0 that cycle; IDLE the next cycle.
- src1=0xFFFFFFFD (-3), src2=5 → result_o=0xFFFFFFF1. Also 0x80000000 × 2 → result_o=0x00000000 (overflow truncation).
- EARLY_EXIT=1: src1=0x10, src2=3 → 2 RUN cycles, done_o at T+3, result_o=0x30. Then src2=0 → 1 RUN cycle, result_o=0.
- Two consecutive muls (5×5 then 9×9), start_i held through DONE → each produces exactly one done_o pulse with 25 and 81 in turn. No spurious restart in DONE; the second start is accepted the cycle after DONE.
- flush_i pulsed in RUN cycle 10 → IDLE next cycle, done_o never asserts, stall_o drops. A new 2×3 then completes with result_o=6.
- rst_i asserted asynchronously mid-RUN (between clock edges) → stall_o, done_o and result_o go to 0 immediately. After release, start with 4×4 completes normally with 16.
